// File: rtl/ee354_snake_body.sv
// ee354_snake_body
//   Snake movement/body engine. On each accepted move tick the head steps one
//   cell in the committed direction, wall/self collision is detected, growth on
//   food is handled, and a per-cell occupancy bitmap is maintained for display.
//   The body is a circular coordinate buffer (head/tail pointers).
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   Init                synchronous re-initialise (level, highest priority)
//   Run                 moves permitted
//   Tick                one-cycle move strobe
//   Dir, Dir_Valid      requested direction (00 up, 01 right, 10 down, 11 left)
//   Food_X, Food_Y      current food cell
//   Query_X, Query_Y    display cell to test
//   Cell_Snake          occupancy of the query cell (combinational)
//   Head_X, Head_Y      current head cell
//   Length              current snake length (saturates at MAX_LEN)
//   Collision           sticky fatal-move flag
//   Ate                 one-cycle pulse when a move consumed food
//   Busy                high while a move is being computed/applied
module ee354_snake_body #(
  parameter int GRID     = 15,
  parameter int MAX_LEN  = 225,
  parameter int INIT_LEN = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Run,
  input  logic       Tick,
  input  logic [1:0] Dir,
  input  logic       Dir_Valid,
  input  logic [3:0] Food_X,
  input  logic [3:0] Food_Y,
  input  logic [3:0] Query_X,
  input  logic [3:0] Query_Y,
  output logic       Cell_Snake,
  output logic [3:0] Head_X,
  output logic [3:0] Head_Y,
  output logic [7:0] Length,
  output logic       Collision,
  output logic       Ate,
  output logic       Busy
);

  localparam int NC = GRID * GRID;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPDATE, S_DEAD} state_t;

  state_t          state;
  logic [3:0]      buf_x [MAX_LEN];
  logic [3:0]      buf_y [MAX_LEN];
  logic [7:0]      head_ptr, tail_ptr;
  logic [NC-1:0]   occ;
  logic [1:0]      cur_dir, pend_dir;
  logic [3:0]      nx_q, ny_q;
  logic            grow_q;

  logic [3:0]      nx, ny, tail_x, tail_y;
  logic            wall, grow, self_hit;
  logic [1:0]      eff_dir;

  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 8'(y) * 8'(GRID) + 8'(x);
  endfunction

  function automatic logic [7:0] ptr_next(input logic [7:0] p);
    return (p == 8'(MAX_LEN - 1)) ? '0 : p + 8'd1;
  endfunction

  assign Cell_Snake = ({1'b0, Query_X} < 5'(GRID)) && ({1'b0, Query_Y} < 5'(GRID))
                      ? occ[cell_idx(Query_X, Query_Y)] : 1'b0;

  assign tail_x = buf_x[tail_ptr];
  assign tail_y = buf_y[tail_ptr];

  // The move uses the pending direction, which is what commits at CALC.
  always_comb begin
    nx   = Head_X;
    ny   = Head_Y;
    wall = 1'b0;
    unique case (pend_dir)
      2'b00: if (Head_Y == 4'd0) wall = 1'b1; else ny = Head_Y - 4'd1;
      2'b01: if (Head_X == 4'(GRID - 1)) wall = 1'b1; else nx = Head_X + 4'd1;
      2'b10: if (Head_Y == 4'(GRID - 1)) wall = 1'b1; else ny = Head_Y + 4'd1;
      default: if (Head_X == 4'd0) wall = 1'b1; else nx = Head_X - 4'd1;
    endcase
    grow     = (nx == Food_X) && (ny == Food_Y) && (Length < 8'(MAX_LEN));
    // The tail cell is vacated this move unless the snake grows.
    self_hit = occ[cell_idx(nx, ny)] && !((nx == tail_x) && (ny == tail_y) && !grow);
  end

  // Reversal is judged against the direction that is committed after this edge.
  assign eff_dir = (state == S_CALC) ? pend_dir : cur_dir;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        buf_x[i] <= '0;
        buf_y[i] <= '0;
      end
      buf_x[0]  <= 4'd4;  buf_y[0] <= 4'd7;
      buf_x[1]  <= 4'd5;  buf_y[1] <= 4'd7;
      buf_x[2]  <= 4'd6;  buf_y[2] <= 4'd7;
      occ       <= '0;
      occ[cell_idx(4'd4, 4'd7)] <= 1'b1;
      occ[cell_idx(4'd5, 4'd7)] <= 1'b1;
      occ[cell_idx(4'd6, 4'd7)] <= 1'b1;
      tail_ptr  <= 8'd0;
      head_ptr  <= 8'd2;
      Head_X    <= 4'd6;
      Head_Y    <= 4'd7;
      Length    <= 8'(INIT_LEN);
      cur_dir   <= 2'b01;
      pend_dir  <= 2'b01;
      Collision <= 1'b0;
      Ate       <= 1'b0;
      Busy      <= 1'b0;
      nx_q      <= '0;
      ny_q      <= '0;
      grow_q    <= 1'b0;
    end else if (Init) begin
      state     <= S_IDLE;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        buf_x[i] <= '0;
        buf_y[i] <= '0;
      end
      buf_x[0]  <= 4'd4;  buf_y[0] <= 4'd7;
      buf_x[1]  <= 4'd5;  buf_y[1] <= 4'd7;
      buf_x[2]  <= 4'd6;  buf_y[2] <= 4'd7;
      occ       <= '0;
      occ[cell_idx(4'd4, 4'd7)] <= 1'b1;
      occ[cell_idx(4'd5, 4'd7)] <= 1'b1;
      occ[cell_idx(4'd6, 4'd7)] <= 1'b1;
      tail_ptr  <= 8'd0;
      head_ptr  <= 8'd2;
      Head_X    <= 4'd6;
      Head_Y    <= 4'd7;
      Length    <= 8'(INIT_LEN);
      cur_dir   <= 2'b01;
      pend_dir  <= 2'b01;
      Collision <= 1'b0;
      Ate       <= 1'b0;
      Busy      <= 1'b0;
      nx_q      <= '0;
      ny_q      <= '0;
      grow_q    <= 1'b0;
    end else begin
      Ate <= 1'b0;
      if (Dir_Valid && (Dir != (eff_dir ^ 2'b10)))
        pend_dir <= Dir;
      unique case (state)
        S_IDLE: begin
          if (Tick && Run && !Collision) begin
            state <= S_CALC;
            Busy  <= 1'b1;
          end
        end
        S_CALC: begin
          cur_dir <= pend_dir;
          nx_q    <= nx;
          ny_q    <= ny;
          grow_q  <= grow;
          if (wall || self_hit) begin
            Collision <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_DEAD;
          end else begin
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // Clear before set: a head entering the vacated tail cell stays set.
          if (!grow_q) begin
            occ[cell_idx(tail_x, tail_y)] <= 1'b0;
            tail_ptr <= ptr_next(tail_ptr);
          end
          occ[cell_idx(nx_q, ny_q)] <= 1'b1;
          head_ptr                  <= ptr_next(head_ptr);
          buf_x[ptr_next(head_ptr)] <= nx_q;
          buf_y[ptr_next(head_ptr)] <= ny_q;
          Head_X                    <= nx_q;
          Head_Y                    <= ny_q;
          if (grow_q) begin
            Length <= Length + 8'd1;
            Ate    <= 1'b1;
          end
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_DEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ee354_snake_body.sv
`timescale 1ns/1ps
module tb_ee354_snake_body;

  localparam int G = 15;

  logic       Clk = 1'b0;
  logic       Reset, Init, Run, Tick, Dir_Valid;
  logic [1:0] Dir;
  logic [3:0] Food_X, Food_Y, Query_X, Query_Y;
  logic       Cell_Snake, Collision, Ate, Busy;
  logic [3:0] Head_X, Head_Y;
  logic [7:0] Length;

  always #5 Clk = ~Clk;

  ee354_snake_body #(.GRID(15), .MAX_LEN(225), .INIT_LEN(3)) dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .Run(Run), .Tick(Tick),
    .Dir(Dir), .Dir_Valid(Dir_Valid), .Food_X(Food_X), .Food_Y(Food_Y),
    .Query_X(Query_X), .Query_Y(Query_Y), .Cell_Snake(Cell_Snake),
    .Head_X(Head_X), .Head_Y(Head_Y), .Length(Length),
    .Collision(Collision), .Ate(Ate), .Busy(Busy)
  );

  typedef struct packed {
    logic [3:0]   hx;
    logic [3:0]   hy;
    logic [7:0]   len;
    logic         coll;
    logic         ate;
    logic [255:0] map;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------- reference model (snake as a coordinate list) ----------
  int sx[$], sy[$];
  int cur, pend;
  bit dead;
  int dxs[4] = '{0, 1, 0, -1};
  int dys[4] = '{-1, 0, 1, 0};

  function automatic void model_init();
    sx = '{4, 5, 6};
    sy = '{7, 7, 7};
    cur = 1; pend = 1; dead = 0;
  endfunction

  function automatic exp_t model_exp(logic ate);
    exp_t e;
    e = '0;
    e.hx = 4'(sx[sx.size()-1]);
    e.hy = 4'(sy[sy.size()-1]);
    e.len = 8'(sx.size());
    e.coll = dead;
    e.ate = ate;
    foreach (sx[i]) e.map[sy[i]*G + sx[i]] = 1'b1;
    return e;
  endfunction

  function automatic void model_dir(int d);
    if (!((dxs[d] + dxs[cur] == 0) && (dys[d] + dys[cur] == 0))) pend = d;
  endfunction

  function automatic void model_tick(int fx, int fy, logic run);
    int nx, ny;
    bit wall, grow, hit;
    if (!run || dead) return;
    cur = pend;
    nx = sx[sx.size()-1] + dxs[cur];
    ny = sy[sy.size()-1] + dys[cur];
    wall = (nx < 0) || (nx >= G) || (ny < 0) || (ny >= G);
    grow = (nx == fx) && (ny == fy) && (sx.size() < 225);
    hit = 0;
    for (int i = (grow ? 0 : 1); i < sx.size(); i++)
      if (sx[i] == nx && sy[i] == ny) hit = 1;
    if (wall || hit) begin
      dead = 1;
      sb.push_back(model_exp(1'b0));
    end else begin
      sx.push_back(nx);
      sy.push_back(ny);
      if (!grow) begin
        void'(sx.pop_front());
        void'(sy.pop_front());
      end
      sb.push_back(model_exp(grow));
    end
  endfunction

  // ---------------- monitor ------------------------------------------------
  exp_t cur_exp;
  logic init_q = 1'b0;
  logic prev_busy = 1'b0;
  int   age = 0;
  int   busy_len = 0;

  always @(posedge Clk) init_q <= Init;

  function automatic exp_t init_exp();
    exp_t e;
    e = '0;
    e.hx = 4'd6; e.hy = 4'd7; e.len = 8'd3;
    e.map[7*G + 4] = 1'b1;
    e.map[7*G + 5] = 1'b1;
    e.map[7*G + 6] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    logic ate_exp, expb;
    int mism, fx, fy, fg, fe;
    forever begin
      @(negedge Clk);
      ate_exp = 1'b0;
      if (Reset || init_q) begin
        cur_exp = init_exp();
      end else if (prev_busy && !Busy) begin
        if (sb.size() > 0) begin
          cur_exp = sb.pop_front();
          ate_exp = cur_exp.ate;
          age = 0;
        end else begin
          total++; bad++;
          $display("FAIL unexpected_move: got a completed move expected none (t=%0t)", $time);
        end
      end
      if (sb.size() > 0) begin
        age++;
        if (age > 6) begin
          total++; bad++;
          $display("FAIL move_timeout: got no completion expected one within 6 cycles");
          void'(sb.pop_front());
          age = 0;
        end
      end
      busy_len = Busy ? busy_len + 1 : 0;
      if (busy_len == 5) begin
        total++; bad++;
        $display("FAIL busy_stuck: got Busy high 5 cycles expected at most 2");
      end
      prev_busy = Busy;
      chk("ate", 32'(Ate), 32'(ate_exp));
      if (!Busy) begin
        chk("head_x", 32'(Head_X), 32'(cur_exp.hx));
        chk("head_y", 32'(Head_Y), 32'(cur_exp.hy));
        chk("length", 32'(Length), 32'(cur_exp.len));
        chk("collision", 32'(Collision), 32'(cur_exp.coll));
        mism = 0; fx = 0; fy = 0; fg = 0; fe = 0;
        for (int y = 0; y < 16; y++) begin
          for (int x = 0; x < 16; x++) begin
            Query_X = 4'(x);
            Query_Y = 4'(y);
            #0.001;
            expb = (x < G && y < G) ? cur_exp.map[y*G + x] : 1'b0;
            if (Cell_Snake !== expb) begin
              if (mism == 0) begin fx = x; fy = y; fg = int'(Cell_Snake); fe = int'(expb); end
              mism++;
            end
          end
        end
        total++;
        if (mism != 0) begin
          bad++;
          $display("FAIL cell_map: %0d cells differ, first (%0d,%0d) got %0d expected %0d (t=%0t)",
                   mism, fx, fy, fg, fe, $time);
        end
      end
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(int fx, int fy);
    Food_X = 4'(fx);
    Food_Y = 4'(fy);
    Tick = 1'b1;
    model_tick(fx, fy, Run);
    cyc();
    Tick = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) cyc();
    cyc(); cyc();
  endtask

  task automatic dir_req(int d);
    Dir = 2'(d);
    Dir_Valid = 1'b1;
    model_dir(d);
    cyc();
    Dir_Valid = 1'b0;
  endtask

  task automatic init_pulse();
    Init = 1'b1;
    model_init();
    cyc();
    Init = 1'b0;
    cyc();
  endtask

  // Init lands while the move is in CALC: the move must be abandoned.
  task automatic tick_then_init();
    Food_X = 4'd0;
    Food_Y = 4'd0;
    Tick = 1'b1;
    cyc();
    Tick = 1'b0;
    Init = 1'b1;
    model_init();
    cyc();
    Init = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  initial begin
    int ax, ay, fx, fy, r;
    Reset = 1'b1; Init = 1'b0; Run = 1'b0; Tick = 1'b0;
    Dir = 2'b00; Dir_Valid = 1'b0; Food_X = 4'd0; Food_Y = 4'd0;
    model_init();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    Run = 1'b1;
    cyc();

    // three plain moves, then growth onto food straight ahead
    repeat (3) tick(0, 0);
    tick(10, 7);
    // reverse request ignored, then turn up
    dir_req(3);
    dir_req(0);
    tick(0, 0);

    // run into the right wall; later ticks are ignored
    init_pulse();
    repeat (8) tick(0, 0);
    tick(0, 0);
    tick(0, 0);

    // box loop at length 4 (legal), then at length 5 (fatal)
    init_pulse();
    tick(7, 7);
    dir_req(0); tick(0, 0);
    dir_req(3); tick(0, 0);
    dir_req(2); tick(0, 0);
    dir_req(1); tick(0, 0);
    tick(8, 7);
    dir_req(0); tick(0, 0);
    dir_req(3); tick(0, 0);
    dir_req(2); tick(0, 0);

    // Init during CALC, then Run low with a pending direction change
    init_pulse();
    tick_then_init();
    Run = 1'b0;
    dir_req(2);
    tick(0, 0);
    Run = 1'b1;
    tick(0, 0);

    // randomized play
    init_pulse();
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (dead && r < 6) begin
        init_pulse();
      end else if (r < 3) begin
        dir_req($urandom_range(0, 3));
        if (r == 0) dir_req($urandom_range(0, 3));
      end else if (r == 3) begin
        Run = ($urandom_range(0, 3) != 0);
        cyc();
      end else if (r == 9 && !dead && Run) begin
        tick_then_init();
      end else begin
        ax = sx[sx.size()-1] + dxs[pend];
        ay = sy[sy.size()-1] + dys[pend];
        if ($urandom_range(0, 1) == 1 && ax >= 0 && ax < G && ay >= 0 && ay < G) begin
          fx = ax; fy = ay;
        end else begin
          fx = $urandom_range(0, G - 1);
          fy = $urandom_range(0, G - 1);
        end
        tick(fx, fy);
      end
    end

    repeat (4) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
